// File: rtl/raw_depacker.sv
`default_nettype none
// ============================================================================
// Module      : raw_depacker
// Description : Unpacks MIPI CSI-2 RAW10 packed payload (8 bytes/cycle) into
//               eight left-justified PIXEL_WIDTH-bit pixels per output word.
//               Optional macro RAW12_SUPPORT_EN adds a raw_mode_i port that
//               selects RAW12 unpacking per line.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_depacker #(
    parameter int PIXEL_WIDTH   = 14,
    parameter int PIXEL_PER_CLK = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [63:0]                          data_i,
    input  logic                                 data_valid_i,
    input  logic                                 line_valid_i,
`ifdef RAW12_SUPPORT_EN
    input  logic                                 raw_mode_i,
`endif
    output logic [PIXEL_PER_CLK*PIXEL_WIDTH-1:0] output_o,
    output logic                                 output_valid_o,
    output logic                                 line_valid_o
);

    localparam int C_WORD_W = PIXEL_PER_CLK * PIXEL_WIDTH;

    // Residual bytes of an incomplete group live in the low bytes of r_buf;
    // bytes at or above r_fill are always zero so new data can be OR-ed in.
    logic [127:0]        r_buf;
    logic [4:0]          r_fill;
    // Set once line_valid_i has been seen low; gates acceptance so a line
    // interrupted by reset is not resumed mid-group.
    logic                r_armed;

    logic                w_accept;
    logic                w_emit;
    logic [4:0]          w_group;
    logic [4:0]          w_total;
    logic [127:0]        w_comb;
    logic [127:0]        w_rest;
    logic [C_WORD_W-1:0] w_word;

`ifdef RAW12_SUPPORT_EN
    logic r_raw_mode;

    // Packing mode is latched between lines and held for the whole line.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_raw_mode <= 1'b0;
        end else if (!line_valid_i) begin
            r_raw_mode <= raw_mode_i;
        end
    end

    assign w_group = r_raw_mode ? 5'd12 : 5'd10;
`else
    assign w_group = 5'd10;
`endif

    assign w_accept = data_valid_i & line_valid_i & r_armed;
    assign w_total  = r_fill + 5'd8;
    assign w_emit   = w_accept && (w_total >= w_group);
    // Residual never exceeds 8 bytes, so residual + 8 new bytes fits in 16.
    assign w_comb   = r_buf | ({64'd0, data_i} << {r_fill, 3'b000});
    assign w_rest   = w_comb >> {w_group, 3'b000};

    // Per-lane unpacking from the lowest group bytes of the combined buffer.
    generate
        for (genvar k = 0; k < PIXEL_PER_CLK; k++) begin : g_lane
            localparam int C_M10 = (5 * (k / 4) + (k % 4)) * 8;
            localparam int C_L10 = (5 * (k / 4) + 4) * 8 + 2 * (k % 4);
            logic [PIXEL_WIDTH-1:0] w_pix10;
            assign w_pix10 = {w_comb[C_M10 +: 8], w_comb[C_L10 +: 2],
                              {(PIXEL_WIDTH-10){1'b0}}};
`ifdef RAW12_SUPPORT_EN
            localparam int C_M12 = (3 * (k / 2) + (k % 2)) * 8;
            localparam int C_L12 = (3 * (k / 2) + 2) * 8 + 4 * (k % 2);
            logic [PIXEL_WIDTH-1:0] w_pix12;
            assign w_pix12 = {w_comb[C_M12 +: 8], w_comb[C_L12 +: 4],
                              {(PIXEL_WIDTH-12){1'b0}}};
            assign w_word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = r_raw_mode ? w_pix12 : w_pix10;
`else
            assign w_word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = w_pix10;
`endif
        end
    endgenerate

    // Byte buffer, fill count and line arming.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else if (!line_valid_i) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_armed <= 1'b1;
        end else if (w_accept) begin
            if (w_emit) begin
                r_buf  <= w_rest;
                r_fill <= w_total - w_group;
            end else begin
                r_buf  <= w_comb;
                r_fill <= w_total;
            end
        end
    end

    // Registered output word, valid pulse and delayed line valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            output_o       <= '0;
            output_valid_o <= 1'b0;
            line_valid_o   <= 1'b0;
        end else begin
            output_valid_o <= w_emit;
            line_valid_o   <= line_valid_i;
            if (w_emit) begin
                output_o <= w_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_raw_depacker.sv
`default_nettype none
// ============================================================================
// Module      : tb_raw_depacker
// Description : Directed self-checking bench for raw_depacker (RAW10 default,
//               RAW12 scenario when RAW12_SUPPORT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_raw_depacker;

    localparam int PW = 14;
    localparam int WW = 8 * PW;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [63:0]   data_i;
    logic          data_valid_i;
    logic          line_valid_i;
    logic          raw_mode_i;
    logic [WW-1:0] output_o;
    logic          output_valid_o;
    logic          line_valid_o;

    int checks = 0;
    int errors = 0;

    raw_depacker #(.PIXEL_WIDTH(PW), .PIXEL_PER_CLK(8)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .data_i         (data_i),
        .data_valid_i   (data_valid_i),
        .line_valid_i   (line_valid_i),
`ifdef RAW12_SUPPORT_EN
        .raw_mode_i     (raw_mode_i),
`endif
        .output_o       (output_o),
        .output_valid_o (output_valid_o),
        .line_valid_o   (line_valid_o)
    );

    always #5 clk_i = ~clk_i;

    // Eight lanes built from a 4-lane repeating pattern, lane 0 in LS bits.
    function automatic logic [WW-1:0] rep4(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c, input logic [PW-1:0] d);
        return {d, c, b, a, d, c, b, a};
    endfunction

    // Input word number cyc of a stream that repeats a glen-byte group.
    function automatic logic [63:0] stream_word(input logic [95:0] grp, input int glen, input int cyc);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) begin
            w[i*8 +: 8] = grp[((cyc * 8 + i) % glen) * 8 +: 8];
        end
        return w;
    endfunction

    // Drive one cycle of inputs and return 1 time unit after the sampling edge.
    task automatic drive(input logic [63:0] d, input logic dv, input logic lv);
        data_i       = d;
        data_valid_i = dv;
        line_valid_i = lv;
        @(posedge clk_i);
        #1;
    endtask

    localparam logic [95:0] GRP10 = 96'hE4_78_56_34_12;
    localparam logic [95:0] GRP12 = 96'h21_CD_AB;

    task automatic test_reset();
        reset_i = 1'b1;
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        checks++;
        if (output_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", output_valid_o);
        end
        checks++;
        if (line_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_line_valid: got %b want 0", line_valid_o);
        end
        checks++;
        if (output_o !== '0) begin
            errors++; $display("FAIL reset_output: got %h want 0", output_o);
        end
        reset_i = 1'b0;
        drive(64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_all_ones();
        logic [WW-1:0] exp_w;
        int            pulses;
        exp_w  = rep4(14'h3FF0, 14'h3FF0, 14'h3FF0, 14'h3FF0);
        pulses = 0;
        drive(64'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
            if (output_valid_o === 1'b1) begin
                pulses++;
                checks++;
                if (output_o !== exp_w) begin
                    errors++; $display("FAIL ones_word[%0d]: got %h want %h", c, output_o, exp_w);
                end
            end
        end
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL ones_pulses: got %0d want 4", pulses);
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_pattern();
        logic [WW-1:0] exp_w;
        exp_w = rep4(14'h0480, 14'h0D10, 14'h15A0, 14'h1E30);
        drive(64'd0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            drive(stream_word(GRP10, 5, c), 1'b1, 1'b1);
            checks++;
            if (output_valid_o !== ((c % 5) != 0)) begin
                errors++; $display("FAIL pattern_valid[%0d]: got %b want %b", c, output_valid_o, (c % 5) != 0);
            end
            checks++;
            if (line_valid_o !== 1'b1) begin
                errors++; $display("FAIL pattern_line_valid[%0d]: got %b want 1", c, line_valid_o);
            end
            if ((c % 5) != 0) begin
                checks++;
                if (output_o !== exp_w) begin
                    errors++; $display("FAIL pattern_word[%0d]: got %h want %h", c, output_o, exp_w);
                end
            end
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_line_drop();
        logic [WW-1:0] exp_w;
        int            words;
        exp_w = rep4(14'h0480, 14'h0D10, 14'h15A0, 14'h1E30);
        words = 0;
        drive(64'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(stream_word(GRP10, 5, c), 1'b1, 1'b1);
            if (output_valid_o === 1'b1) words++;
        end
        // Data while line is low must be ignored and the residual dropped.
        drive(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        if (output_valid_o === 1'b1) words++;
        checks++;
        if (words != 2) begin
            errors++; $display("FAIL drop_words: got %0d want 2", words);
        end
        checks++;
        if (line_valid_o !== 1'b0) begin
            errors++; $display("FAIL drop_line_valid: got %b want 0", line_valid_o);
        end
        drive(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
        checks++;
        if (output_valid_o !== 1'b0) begin
            errors++; $display("FAIL drop_no_emit: got %b want 0", output_valid_o);
        end
        for (int c = 0; c < 2; c++) begin
            drive(stream_word(GRP10, 5, c), 1'b1, 1'b1);
        end
        checks++;
        if (output_valid_o !== 1'b1 || output_o !== exp_w) begin
            errors++; $display("FAIL drop_next_line: got v=%b %h want v=1 %h", output_valid_o, output_o, exp_w);
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_toggle();
        logic [WW-1:0] exp_w;
        exp_w = rep4(14'h0480, 14'h0D10, 14'h15A0, 14'h1E30);
        drive(64'd0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            drive(stream_word(GRP10, 5, k), 1'b1, 1'b1);
            checks++;
            if (output_valid_o !== ((k % 5) != 0)) begin
                errors++; $display("FAIL toggle_valid[%0d]: got %b want %b", k, output_valid_o, (k % 5) != 0);
            end
            if ((k % 5) != 0) begin
                checks++;
                if (output_o !== exp_w) begin
                    errors++; $display("FAIL toggle_word[%0d]: got %h want %h", k, output_o, exp_w);
                end
            end
            drive(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1);
            checks++;
            if (output_valid_o !== 1'b0) begin
                errors++; $display("FAIL toggle_idle[%0d]: got %b want 0", k, output_valid_o);
            end
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [WW-1:0] exp_w;
        int            bad;
        exp_w = rep4(14'h0480, 14'h0D10, 14'h15A0, 14'h1E30);
        drive(64'd0, 1'b0, 1'b0);
        drive(stream_word(GRP10, 5, 0), 1'b1, 1'b1);
        drive(stream_word(GRP10, 5, 1), 1'b1, 1'b1);
        // Residual is now 6 bytes.
        reset_i = 1'b1;
        drive(stream_word(GRP10, 5, 2), 1'b1, 1'b1);
        reset_i = 1'b0;
        checks++;
        if (output_valid_o !== 1'b0 || output_o !== '0 || line_valid_o !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: got v=%b lv=%b %h want all 0", output_valid_o, line_valid_o, output_o);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            drive(stream_word(GRP10, 5, c), 1'b1, 1'b1);
            if (output_valid_o !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d pulses want 0", bad);
        end
        drive(64'd0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(stream_word(GRP10, 5, c), 1'b1, 1'b1);
            checks++;
            if (output_valid_o !== (c != 0) || (c != 0 && output_o !== exp_w)) begin
                errors++; $display("FAIL midreset_line[%0d]: got v=%b %h want v=%b %h", c, output_valid_o, output_o, c != 0, exp_w);
            end
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask

`ifdef RAW12_SUPPORT_EN
    task automatic test_raw12();
        logic [WW-1:0] exp_w;
        // 0xAB1 and 0xCD2 left-justified into 14 bits.
        exp_w = rep4(14'h2AC4, 14'h3348, 14'h2AC4, 14'h3348);
        raw_mode_i = 1'b1;
        drive(64'd0, 1'b0, 1'b0);
        raw_mode_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(stream_word(GRP12, 3, c), 1'b1, 1'b1);
            checks++;
            if (output_valid_o !== ((c % 3) != 0)) begin
                errors++; $display("FAIL raw12_valid[%0d]: got %b want %b", c, output_valid_o, (c % 3) != 0);
            end
            if ((c % 3) != 0) begin
                checks++;
                if (output_o !== exp_w) begin
                    errors++; $display("FAIL raw12_word[%0d]: got %h want %h", c, output_o, exp_w);
                end
            end
        end
        drive(64'd0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        reset_i      = 1'b1;
        data_i       = 64'd0;
        data_valid_i = 1'b0;
        line_valid_i = 1'b0;
        raw_mode_i   = 1'b0;
        test_reset();
        test_all_ones();
        test_pattern();
        test_line_drop();
        test_toggle();
        test_reset_mid();
`ifdef RAW12_SUPPORT_EN
        test_raw12();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
